id_stage_reg: RTL
=================

ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of PC and register operand fields.
REQ-002 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  meaning the reset, asynchronous and active-high.
REQ-004 The block SHALL have port freeze  input  1  meaning a memory-wait stall that holds all stored state.
REQ-005 The block SHALL have port flush  input  1  meaning a branch was taken in EX, so the instruction in ID is killed.
REQ-006 The block SHALL have port bubble  input  1  meaning a hazard-unit stall that inserts a NOP into EX.
REQ-007 The block SHALL have ports WB_en_in, mem_read_in, mem_write_in, B_in, S_in  input  1 each  meaning the decoded control bits from the control unit.
REQ-008 The block SHALL have port EX_command_in  input  4  meaning the ALU command.
REQ-009 The block SHALL have ports PC_in, Val_Rn_in, Val_Rm_in  input  DATA_W each  meaning the next PC and the register file read values.
REQ-010 The block SHALL have ports imm_in  input  1; shift_operand_in  input  12; signed_imm_24_in  input  24; Dest_in  input  4; src1_in, src2_in  input  4 each; SR_in  input  4 (NZCV).
REQ-011 The block SHALL have a registered output for each *_in above, named without the suffix.
REQ-012 The block SHALL have port valid  output  1  meaning the EX slot holds a real instruction.
REQ-013 The block SHALL have port bubble_count  output  16  meaning a saturating count of bubbles inserted since reset.

Function
REQ-014 Every rising clk SHALL apply exactly one action, in priority order: freeze > flush > bubble > load.
REQ-015 Freeze SHALL hold every output, including valid and bubble_count, unchanged.
REQ-016 Flush SHALL clear all outputs except bubble_count to 0 and set valid=0; bubble_count SHALL be unchanged.
REQ-017 Bubble SHALL clear WB_en, mem_read, mem_write, B, S and EX_command to 0 and set valid=0.
REQ-018 Bubble SHALL load the data fields (PC, Val_Rn, Val_Rm, imm, shift_operand, signed_imm_24, Dest, src1, src2, SR) from the inputs.
REQ-019 Bubble SHALL increment bubble_count by 1, saturating at 16'hFFFF with no wrap.
REQ-020 Load SHALL capture every *_in into its output and set valid=1.
REQ-021 Latency SHALL be 1 cycle from input to output; the block SHALL have no combinational path from any input to any output.
REQ-022 When flush and bubble are asserted together without freeze, flush SHALL win and bubble_count SHALL NOT increment.
REQ-023 When freeze and flush are asserted together, the block SHALL hold; the frozen EX stage keeps flush asserted, so the flush takes effect on the first unfrozen edge.
REQ-024 An instruction held in the block with S=1 SHALL present S for exactly as many cycles as it is held; the block SHALL NOT generate SR update pulses itself.

Reset
REQ-025 rst=1 SHALL immediately force all outputs, valid and bubble_count to 0, independent of clk.
REQ-026 rst SHALL override freeze, flush and bubble.
REQ-027 Reset asserted mid-stall SHALL discard the held instruction; the first edge after deassertion SHALL apply the normal priority.

Verification
REQ-028 Load: rst pulse, then at edge 1 drive WB_en_in=1, EX_command_in=4'b0010, Val_Rn_in=32'h11, Dest_in=4'h3 -> after edge 1 WB_en=1, EX_command=4'b0010, Val_Rn=32'h11, Dest=3, valid=1.
REQ-029 Freeze: with the above held, set freeze=1 for 3 edges while inputs change -> outputs unchanged for all 3 cycles; after freeze drops, the next edge loads the new inputs.
REQ-030 Bubble: bubble=1 with mem_read_in=1, Dest_in=4'h5 -> mem_read=0, WB_en=0, valid=0, Dest=5, bubble_count=1.
REQ-031 Flush vs bubble: flush=1 and bubble=1 together -> all outputs 0, valid=0, bubble_count unchanged.
REQ-032 Saturation: force 65536 consecutive bubbles -> bubble_count=16'hFFFF and stays there.
REQ-033 Async reset: assert rst between clock edges during freeze -> outputs 0 before the next edge.

Source files
------------

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: captures decoded control and operands from ID for EX.
// It also handles freeze, flush and bubble insertion, and keeps a saturating count of bubbles.
module id_stage_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              bubble,
  input  logic              WB_en_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic [3:0]        EX_command_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Val_Rn_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        Dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        SR_in,
  output logic              WB_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic              B,
  output logic              S,
  output logic [3:0]        EX_command,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] Val_Rn,
  output logic [DATA_W-1:0] Val_Rm,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm_24,
  output logic [3:0]        Dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic [3:0]        SR,
  output logic              valid,
  output logic [15:0]       bubble_count
);

  // Priority on each edge: freeze holds everything, flush kills, bubble inserts a NOP, else load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_en         <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      B             <= 1'b0;
      S             <= 1'b0;
      EX_command    <= 4'd0;
      PC            <= '0;
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      imm           <= 1'b0;
      shift_operand <= 12'd0;
      signed_imm_24 <= 24'd0;
      Dest          <= 4'd0;
      src1          <= 4'd0;
      src2          <= 4'd0;
      SR            <= 4'd0;
      valid         <= 1'b0;
      bubble_count  <= 16'd0;
    end else if (!freeze) begin
      if (flush) begin
        WB_en         <= 1'b0;
        mem_read      <= 1'b0;
        mem_write     <= 1'b0;
        B             <= 1'b0;
        S             <= 1'b0;
        EX_command    <= 4'd0;
        PC            <= '0;
        Val_Rn        <= '0;
        Val_Rm        <= '0;
        imm           <= 1'b0;
        shift_operand <= 12'd0;
        signed_imm_24 <= 24'd0;
        Dest          <= 4'd0;
        src1          <= 4'd0;
        src2          <= 4'd0;
        SR            <= 4'd0;
        valid         <= 1'b0;
      end else begin
        // Data fields travel with a bubble too; only the control bits are squashed.
        PC            <= PC_in;
        Val_Rn        <= Val_Rn_in;
        Val_Rm        <= Val_Rm_in;
        imm           <= imm_in;
        shift_operand <= shift_operand_in;
        signed_imm_24 <= signed_imm_24_in;
        Dest          <= Dest_in;
        src1          <= src1_in;
        src2          <= src2_in;
        SR            <= SR_in;
        if (bubble) begin
          WB_en      <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          B          <= 1'b0;
          S          <= 1'b0;
          EX_command <= 4'd0;
          valid      <= 1'b0;
          if (bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'd1;
        end else begin
          WB_en      <= WB_en_in;
          mem_read   <= mem_read_in;
          mem_write  <= mem_write_in;
          B          <= B_in;
          S          <= S_in;
          EX_command <= EX_command_in;
          valid      <= 1'b1;
        end
      end
    end
  end

endmodule
